lamp_fpu_sqrt: RTL and testbench

- Iterative square-root unit for the lampFPU bfloat16-style format: 1 sign bit, 8-bit biased exponent (bias 127), 7-bit fraction.
- Takes a pre-unpacked operand (sign, biased exponent, mantissa with explicit hidden bit).
- Returns sign, biased exponent and hidden-bit mantissa of the square root after a fixed multi-cycle latency.
- Sits beside the add/mul/div units inside the lampFPU datapath; packing and rounding-mode selection happen outside.

---
 rtl/lamp_fpu_sqrt.sv | 150 +++++++++++++++
 tb/tb_lamp_fpu_sqrt.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_fpu_sqrt.sv
// lamp_fpu_sqrt: restoring square root for the lampFPU bfloat16-style format.
// Compile-time option LAMP_SQRT_ROUND_EN adds a guard iteration and round-half-up.
module lamp_fpu_sqrt #(
  parameter int E_DW = 8,
  parameter int F_DW = 7,
  parameter int BIAS = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            doSqrt_i,
  input  logic            signum_op_i,
  input  logic [E_DW-1:0] extExp_op_i,
  input  logic [F_DW:0]   extMant_op_i,
  output logic            valid_o,
  output logic            s_res_o,
  output logic [E_DW-1:0] e_res_o,
  output logic [F_DW:0]   f_res_o
);
  // Handshake: doSqrt_i is a level request sampled only in IDLE (operands latched on
  // that edge); valid_o is a single-cycle strobe with no backpressure.
  localparam int M_DW = F_DW + 1;
`ifdef LAMP_SQRT_ROUND_EN
  localparam int N_IT = M_DW + 1;
`else
  localparam int N_IT = M_DW;
`endif
  localparam int RAD_W = 2 * N_IT;
  localparam int REM_W = N_IT + 2;
  localparam int CNT_W = $clog2(N_IT + 1);
  localparam logic [CNT_W-1:0] LAST_IT   = CNT_W'(N_IT - 1);
  localparam logic [E_DW:0]    BIAS_ODD  = (E_DW + 1)'(BIAS);
  localparam logic [E_DW:0]    BIAS_EVEN = (E_DW + 1)'(BIAS - 1);
  localparam logic [E_DW-1:0]  E_MAX     = '1;
  localparam logic [F_DW:0]    M_ONE     = {1'b1, {F_DW{1'b0}}};
  localparam logic [F_DW:0]    QNAN_F    = {2'b11, {(F_DW - 1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem;
  logic [N_IT-1:0]  root;
  logic [E_DW-1:0]  e_lat;
  logic             sp_flag;
  logic             sp_s;
  logic [E_DW-1:0]  sp_e;
  logic [F_DW:0]    sp_f;

  logic [2*M_DW-1:0] rad_base;
  logic [RAD_W-1:0]  rad_init;
  logic [E_DW:0]     e_sum;
  logic              is_zero;
  logic              is_pinf;
  logic              is_nan;
  logic [REM_W-1:0]  rem_shift;
  logic [REM_W-1:0]  trial;
  logic [REM_W-1:0]  rem_nxt;
  logic              bit_ok;
  logic [N_IT-1:0]   root_nxt;
  logic [F_DW:0]     f_calc;

  always_comb begin
    // Odd biased exponent means an even unbiased one: no extra radicand shift needed.
    rad_base = extExp_op_i[0] ? {1'b0, extMant_op_i, {F_DW{1'b0}}}
                              : {extMant_op_i, {M_DW{1'b0}}};
`ifdef LAMP_SQRT_ROUND_EN
    rad_init = {rad_base, 2'b00};
`else
    rad_init = rad_base;
`endif
    e_sum   = {1'b0, extExp_op_i} + (extExp_op_i[0] ? BIAS_ODD : BIAS_EVEN);
    is_zero = (extExp_op_i == '0);
    is_pinf = (extExp_op_i == E_MAX) && (extMant_op_i == M_ONE) && !signum_op_i;
    is_nan  = !is_zero && !is_pinf && ((extExp_op_i == E_MAX) || signum_op_i);

    // One restoring step: bring down two radicand bits, try root*4+1.
    rem_shift = (rem << 2) | REM_W'(rad[RAD_W-1 -: 2]);
    trial     = {root, 2'b01};
    bit_ok    = (rem_shift >= trial);
    rem_nxt   = bit_ok ? (rem_shift - trial) : rem_shift;
    root_nxt  = {root[N_IT-2:0], bit_ok};
`ifdef LAMP_SQRT_ROUND_EN
    f_calc = root_nxt[N_IT-1:1] + {{F_DW{1'b0}}, root_nxt[0]};
`else
    f_calc = root_nxt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      e_lat   <= '0;
      sp_flag <= 1'b0;
      sp_s    <= 1'b0;
      sp_e    <= '0;
      sp_f    <= '0;
      valid_o <= 1'b0;
      s_res_o <= 1'b0;
      e_res_o <= '0;
      f_res_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (doSqrt_i) begin
            state   <= S_CALC;
            cnt     <= '0;
            rad     <= rad_init;
            rem     <= '0;
            root    <= '0;
            e_lat   <= E_DW'(e_sum >> 1);
            sp_flag <= is_zero | is_pinf | is_nan;
            sp_s    <= is_zero & signum_op_i;
            sp_e    <= is_zero ? '0 : E_MAX;
            sp_f    <= is_zero ? '0 : (is_pinf ? M_ONE : QNAN_F);
          end
        end
        S_CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_IT) begin
            // Special operands still run the datapath so latency stays fixed.
            state   <= S_DONE;
            valid_o <= 1'b1;
            if (sp_flag) begin
              s_res_o <= sp_s;
              e_res_o <= sp_e;
              f_res_o <= sp_f;
            end else begin
              s_res_o <= 1'b0;
              e_res_o <= e_lat;
              f_res_o <= f_calc;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lamp_fpu_sqrt.sv
// Self-checking bench for lamp_fpu_sqrt against an integer-arithmetic square-root model.
// Build with LAMP_SQRT_ROUND_EN defined to check the rounding variant.
module tb_lamp_fpu_sqrt;
`ifdef LAMP_SQRT_ROUND_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif
  localparam int PERIOD = LAT + 2;

  logic       clk_tb = 1'b0;
  logic       rst = 1'b1;
  logic       do_sqrt = 1'b0;
  logic       sign = 1'b0;
  logic [7:0] exp_in = 8'h00;
  logic [7:0] mant_in = 8'h00;
  logic       valid;
  logic       s_res;
  logic [7:0] e_res;
  logic [7:0] f_res;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_tb = ~clk_tb;

  lamp_fpu_sqrt dut (
    .clk          (clk_tb),
    .rst          (rst),
    .doSqrt_i     (do_sqrt),
    .signum_op_i  (sign),
    .extExp_op_i  (exp_in),
    .extMant_op_i (mant_in),
    .valid_o      (valid),
    .s_res_o      (s_res),
    .e_res_o      (e_res),
    .f_res_o      (f_res)
  );

  // Reference: {sign, exponent, mantissa} from the numeric definition of the result.
  function automatic logic [16:0] model(input logic s, input logic [7:0] e, input logic [7:0] m);
    int rad;
    int r;
    int ee;
    if (e == 8'h00) return {s, 8'h00, 8'h00};
    if (e == 8'hFF && m == 8'h80 && !s) return {1'b0, 8'hFF, 8'h80};
    if (e == 8'hFF || s) return {1'b0, 8'hFF, 8'hC0};
    if ((int'(e) - 127) % 2 == 0) begin
      rad = int'(m) * 128;
      ee  = (int'(e) + 127) / 2;
    end else begin
      rad = int'(m) * 256;
      ee  = (int'(e) + 126) / 2;
    end
`ifdef LAMP_SQRT_ROUND_EN
    rad = rad * 4;
`endif
    r = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
`ifdef LAMP_SQRT_ROUND_EN
    r = r / 2 + r % 2;
`endif
    return {1'b0, 8'(ee), 8'(r)};
  endfunction

  // Driver: start one operation, scramble inputs after the start edge unless hold is set,
  // wait (bounded) for valid, then step one more edge so the unit is back in IDLE.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [7:0] m, input bit hold,
                        output logic [16:0] res, output int lat, output bit pulse_ok);
    @(negedge clk_tb);
    sign = s; exp_in = e; mant_in = m; do_sqrt = 1'b1;
    @(posedge clk_tb); #1;
    if (!hold) begin
      do_sqrt = 1'b0;
      sign = 1'($urandom_range(1, 0));
      exp_in = 8'($urandom);
      mant_in = 8'($urandom);
    end
    lat = 0;
    res = '0;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(posedge clk_tb); #1;
      if (valid) begin
        lat = k;
        res = {s_res, e_res, f_res};
        break;
      end
    end
    do_sqrt = 1'b0;
    @(posedge clk_tb); #1;
    pulse_ok = !valid;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({valid, s_res, e_res, f_res} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got valid=%b s=%b e=%h f=%h, want all 0", valid, s_res, e_res, f_res);
    end
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b0;
    repeat (2) @(posedge clk_tb);
    #1;
    n_checks++;
    if ({valid, s_res, e_res, f_res} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got valid=%b s=%b e=%h f=%h, want all 0", valid, s_res, e_res, f_res);
    end
  endtask

  task automatic test_directed();
    logic [23:0] vec [10];
    logic [16:0] res;
    logic [16:0] exp_res;
    int lat;
    bit pulse_ok;
    vec = '{{8'h00, 8'h83, 8'hC8}, {8'h00, 8'h7F, 8'h80}, {8'h00, 8'h80, 8'h80},
            {8'h01, 8'h80, 8'h80}, {8'h01, 8'h00, 8'h00}, {8'h00, 8'hFF, 8'h80},
            {8'h00, 8'hFF, 8'hC0}, {8'h01, 8'hFF, 8'h80}, {8'h00, 8'hFE, 8'hFF},
            {8'h00, 8'h01, 8'h80}};
    for (int i = 0; i < 10; i++) begin
      exp_res = model(vec[i][16], vec[i][15:8], vec[i][7:0]);
      run_op(vec[i][16], vec[i][15:8], vec[i][7:0], (i == 0), res, lat, pulse_ok);
      n_checks++;
      if (res !== exp_res) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got s=%b e=%h f=%h, want s=%b e=%h f=%h",
                 i, res[16], res[15:8], res[7:0], exp_res[16], exp_res[15:8], exp_res[7:0]);
      end
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
      end
      n_checks++;
      if (!pulse_ok) begin
        n_fail++;
        $display("FAIL directed_pulse[%0d]: valid still 1 after DONE cycle, want 0", i);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] res;
    logic [16:0] exp_res;
    logic s;
    logic [7:0] e;
    logic [7:0] m;
    int lat;
    bit pulse_ok;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(9, 0);
      s = 1'b0;
      e = 8'($urandom_range(254, 1));
      m = {1'b1, 7'($urandom)};
      if (kind == 0) begin
        e = 8'h00; s = 1'($urandom_range(1, 0)); m = 8'($urandom);
      end else if (kind == 1) begin
        e = 8'hFF; s = 1'($urandom_range(1, 0)); m = (m[0]) ? 8'h80 : m;
      end else if (kind == 2) begin
        s = 1'b1;
      end
      exp_res = model(s, e, m);
      run_op(s, e, m, 1'b0, res, lat, pulse_ok);
      n_checks++;
      if (res !== exp_res || lat !== LAT) begin
        n_fail++;
        $display("FAIL random[%0d] in s=%b e=%h m=%h: got %h lat %0d, want %h lat %0d",
                 i, s, e, m, res, lat, exp_res, LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] res;
    logic [16:0] exp_res;
    int lat;
    bit pulse_ok;
    bit seen;
    @(negedge clk_tb);
    sign = 1'b0; exp_in = 8'h85; mant_in = 8'hF3; do_sqrt = 1'b1;
    @(posedge clk_tb); #1;
    do_sqrt = 1'b0;
    repeat (3) @(posedge clk_tb);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid, s_res, e_res, f_res} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got valid=%b s=%b e=%h f=%h, want all 0", valid, s_res, e_res, f_res);
    end
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(posedge clk_tb); #1;
      if (valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: got valid pulse after abort, want none");
    end
    exp_res = model(1'b0, 8'h82, 8'h9A);
    run_op(1'b0, 8'h82, 8'h9A, 1'b0, res, lat, pulse_ok);
    n_checks++;
    if (res !== exp_res || lat !== LAT) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %h lat %0d, want %h lat %0d", res, lat, exp_res, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] exp_res;
    logic [16:0] got;
    logic [7:0] e;
    logic [7:0] m;
    int seen;
    e = 8'($urandom_range(254, 1));
    m = {1'b1, 7'($urandom)};
    for (int i = 0; i < 4; i++) exp_q.push_back(model(1'b0, e, m));
    @(negedge clk_tb);
    sign = 1'b0; exp_in = e; mant_in = m; do_sqrt = 1'b1;
    @(posedge clk_tb);
    seen = 0;
    for (int c = 1; c <= 4 * PERIOD; c++) begin
      @(posedge clk_tb); #1;
      if (valid) begin
        got = {s_res, e_res, f_res};
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
        n_checks++;
        if (c !== seen * PERIOD + LAT || got !== exp_res) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got %h at cycle %0d, want %h at cycle %0d",
                   seen, got, c, exp_res, seen * PERIOD + LAT);
        end
        seen++;
        if (seen == 4) do_sqrt = 1'b0;
      end
    end
    do_sqrt = 1'b0;
    n_checks++;
    if (seen !== 4) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d pulses, want 4", seen);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
